// File: rtl/store_drain_buffer.sv
// Committed-store buffer: accepts stores from the commit port, holds them in
// program order and drains them one byte per granted cycle to the RAM port.
module store_drain_buffer #(
    parameter int         DEPTH   = 4,
    parameter int         IDX_BIT = 2,
    parameter logic [1:0] IO_SEL  = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        st_ena,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_len,
    output logic        st_done,
    input  logic        mem_gnt,
    input  logic        io_buffer_full,
    output logic        ram_we,
    output logic [31:0] ram_a,
    output logic [7:0]  ram_dout,
    input  logic [31:0] ld_chk_addr,
    input  logic [3:0]  ld_chk_len,
    output logic        ld_conflict,
    output logic        sb_empty,
    output logic        sb_full
);

    typedef enum logic {IDLE, WRITE} state_t;

    localparam logic [IDX_BIT:0]   FULL_CNT = (IDX_BIT + 1)'(DEPTH);
    localparam logic [IDX_BIT:0]   ONE_CNT  = (IDX_BIT + 1)'(1);
    localparam logic [IDX_BIT-1:0] ONE_PTR  = IDX_BIT'(1);

    logic [31:0]        addr_q [DEPTH];
    logic [31:0]        data_q [DEPTH];
    logic [1:0]         len_q  [DEPTH];

    logic [IDX_BIT-1:0] head_q, head_d, tail_q, tail_d;
    logic [IDX_BIT:0]   count_q, count_d;
    logic               acked_q, acked_d;
    logic               st_done_q, st_done_d;
    logic               sb_empty_q, sb_full_q;
    state_t             state_q, state_d;
    logic [1:0]         byte_idx_q, byte_idx_d;

    logic               push, pop, blocked;
    logic [31:0]        head_addr, head_data;
    logic [1:0]         head_len, st_len_n;
    logic [DEPTH-1:0]   hit;

    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign head_len  = len_q[head_q];
    assign blocked   = (head_addr[17:16] == IO_SEL) && io_buffer_full;

    // Lengths other than byte/half collapse to a full word.
    assign st_len_n = (st_len == 4'd0) ? 2'd0 : (st_len == 4'd1) ? 2'd1 : 2'd3;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        acked_d    = acked_q;
        st_done_d  = st_done_q;
        push       = 1'b0;
        pop        = 1'b0;
        ram_we     = 1'b0;
        ram_a      = 32'd0;
        ram_dout   = 8'd0;

        if (rdy) begin
            unique case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_d    = WRITE;
                        byte_idx_d = 2'd0;
                    end
                end
                WRITE: begin
                    if (mem_gnt && !blocked) begin
                        ram_we   = 1'b1;
                        ram_a    = head_addr + 32'(byte_idx_q);
                        ram_dout = head_data[{byte_idx_q, 3'b000} +: 8];
                        if (byte_idx_q == head_len) begin
                            pop        = 1'b1;
                            byte_idx_d = 2'd0;
                            if (count_q <= ONE_CNT) begin
                                state_d = IDLE;
                            end
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // A pop completing this cycle frees a slot for a waiting request.
            push      = st_ena && !acked_q && ((count_q != FULL_CNT) || pop);
            st_done_d = push;
            if (!st_ena) begin
                acked_d = 1'b0;
            end else if (push) begin
                acked_d = 1'b1;
            end

            if (push) begin
                tail_d = tail_q + ONE_PTR;
            end
            if (pop) begin
                head_d = head_q + ONE_PTR;
            end
            if (push && !pop) begin
                count_d = count_q + ONE_CNT;
            end else if (pop && !push) begin
                count_d = count_q - ONE_CNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_idx_q <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            acked_q    <= 1'b0;
            st_done_q  <= 1'b0;
            sb_empty_q <= 1'b1;
            sb_full_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            acked_q    <= acked_d;
            st_done_q  <= st_done_d;
            sb_empty_q <= (count_d == '0);
            sb_full_q  <= (count_d == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
            len_q[tail_q]  <= st_len_n;
        end
    end

    // Modular overlap: the ranges intersect iff one start lies inside the other.
    for (genvar i = 0; i < DEPTH; i++) begin : g_chk
        logic [IDX_BIT-1:0] offs;
        logic [31:0]        fwd, back;
        assign offs   = IDX_BIT'(i) - head_q;
        assign fwd    = ld_chk_addr - addr_q[i];
        assign back   = addr_q[i] - ld_chk_addr;
        assign hit[i] = ({1'b0, offs} < count_q) &&
                        ((fwd <= {30'd0, len_q[i]}) || (back <= {28'd0, ld_chk_len}));
    end

    assign ld_conflict = |hit;
    assign st_done     = st_done_q;
    assign sb_empty    = sb_empty_q;
    assign sb_full     = sb_full_q;

endmodule

// File: tb/tb_store_drain_buffer.sv
// Scoreboard bench for store_drain_buffer: accepted stores queue expected bytes,
// a monitor checks every RAM write, the status flags and the load-overlap flag.
module tb_store_drain_buffer;

    localparam int DEPTH = 4;

    logic        clk, rst_n, rdy, st_ena, st_done, mem_gnt, io_buffer_full;
    logic        ram_we, ld_conflict, sb_empty, sb_full;
    logic [31:0] st_addr, st_data, ram_a, ld_chk_addr;
    logic [3:0]  st_len, ld_chk_len;
    logic [7:0]  ram_dout;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  len;
    } ent_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
        logic        last;
    } byte_t;

    ent_t  pendQ[$];
    byte_t expQ[$];

    int vectors = 0;
    int miscompares = 0;
    int gntMode = 0;
    int ioMode = 0;
    bit ldFix = 0;
    bit monOn = 0;
    logic [31:0] ldAddrFix = 32'd0;
    logic [3:0]  ldLenFix = 4'd0;
    logic [31:0] bases [4] = '{32'h0000_1000, 32'h0000_1004, 32'h0003_0010, 32'hFFFF_FFFC};

    logic        monWe, monIof;
    logic [31:0] monA;
    logic [7:0]  monD;

    store_drain_buffer #(.DEPTH(DEPTH), .IDX_BIT(2), .IO_SEL(2'b11)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .st_ena(st_ena), .st_addr(st_addr), .st_data(st_data), .st_len(st_len),
        .st_done(st_done), .mem_gnt(mem_gnt), .io_buffer_full(io_buffer_full),
        .ram_we(ram_we), .ram_a(ram_a), .ram_dout(ram_dout),
        .ld_chk_addr(ld_chk_addr), .ld_chk_len(ld_chk_len), .ld_conflict(ld_conflict),
        .sb_empty(sb_empty), .sb_full(sb_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] normLen(input logic [3:0] l);
        if (l == 4'd0) return 2'd0;
        if (l == 4'd1) return 2'd1;
        return 2'd3;
    endfunction

    function automatic logic modelConflict();
        foreach (pendQ[e]) begin
            for (int i = 0; i <= int'(pendQ[e].len); i++) begin
                for (int j = 0; j <= int'(ld_chk_len); j++) begin
                    if (pendQ[e].addr + 32'(i) == ld_chk_addr + 32'(j)) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    task automatic recordAccept(input logic [31:0] a, input logic [31:0] d, input logic [3:0] l);
        ent_t  e;
        byte_t b;
        int    n;
        e.addr = a;
        e.data = d;
        e.len  = normLen(l);
        pendQ.push_back(e);
        n = int'(e.len);
        for (int k = 0; k <= n; k++) begin
            b.addr = a + 32'(k);
            b.data = d[8*k +: 8];
            b.last = (k == n);
            expQ.push_back(b);
        end
    endtask

    // Raises a request, waits for its acknowledge and records the expected bytes.
    // Returns at the sample point where st_done was seen.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] l, input bit hold);
        bit got = 0;
        @(posedge clk); #1;
        st_addr = a;
        st_data = d;
        st_len  = l;
        st_ena  = 1'b1;
        for (int w = 0; w < 400 && !got; w++) begin
            @(negedge clk);
            if (st_done) got = 1;
        end
        if (got) begin
            recordAccept(a, d, l);
        end else begin
            checkOutput("ack_timeout", 32'd0, 32'd1);
        end
        if (hold && got) begin
            for (int h = 0; h < 3; h++) begin
                @(negedge clk);
                checkOutput("no_dup_done", st_done, 1'b0);
            end
        end
        st_ena = 1'b0;
    endtask

    task automatic waitDrain();
        for (int w = 0; w < 1000; w++) begin
            if (expQ.size() == 0 && pendQ.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drain_done", (expQ.size() == 0 && pendQ.size() == 0), 1'b1);
    endtask

    // Environment driver: grant, UART-full and load-check inputs.
    initial begin
        mem_gnt = 1'b0;
        io_buffer_full = 1'b0;
        ld_chk_addr = 32'd0;
        ld_chk_len = 4'd0;
        forever begin
            @(posedge clk); #1;
            mem_gnt = (gntMode == 1) || (gntMode == 2 && $urandom_range(0, 3) != 0);
            io_buffer_full = (ioMode == 1) || (ioMode == 2 && $urandom_range(0, 3) == 0);
            if (ldFix) begin
                ld_chk_addr = ldAddrFix;
                ld_chk_len  = ldLenFix;
            end else begin
                ld_chk_addr = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 15)) - 32'd6;
                ld_chk_len  = 4'($urandom_range(0, 15));
            end
        end
    end

    // Monitor: flags and overlap every cycle, scoreboard pop on every write.
    initial begin
        byte_t e;
        forever begin
            @(negedge clk);
            if (monOn) begin
                monWe  = ram_we;
                monA   = ram_a;
                monD   = ram_dout;
                monIof = io_buffer_full;
                #2;
                checkOutput("sb_empty", sb_empty, pendQ.size() == 0);
                checkOutput("sb_full", sb_full, pendQ.size() == DEPTH);
                checkOutput("ld_conflict", ld_conflict, modelConflict());
                if (monWe) begin
                    checkOutput("write_expected", expQ.size() != 0, 1'b1);
                    if (expQ.size() != 0) begin
                        e = expQ.pop_front();
                        checkOutput("ram_a", monA, e.addr);
                        checkOutput("ram_dout", monD, e.data);
                        if (pendQ.size() != 0) begin
                            checkOutput("io_not_blocked",
                                        monIof && pendQ[0].addr[17:16] == 2'b11, 1'b0);
                        end
                        if (e.last && pendQ.size() != 0) void'(pendQ.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int waited;
        bit got;
        rst_n = 1'b0;
        rdy = 1'b1;
        st_ena = 1'b0;
        st_addr = 32'd0;
        st_data = 32'd0;
        st_len = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_st_done", st_done, 1'b0);
        checkOutput("rst_ram_we", ram_we, 1'b0);
        checkOutput("rst_ram_a", ram_a, 32'd0);
        checkOutput("rst_ram_dout", ram_dout, 8'd0);
        checkOutput("rst_sb_empty", sb_empty, 1'b1);
        checkOutput("rst_sb_full", sb_full, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        monOn = 1'b1;

        $display("[TB] single SW drain");
        gntMode = 1;
        applyStimulus(32'h0000_1000, 32'h1122_3344, 4'd3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("sw_byte_we", ram_we, 1'b1);
        end
        @(negedge clk);
        checkOutput("sw_done_empty", sb_empty, 1'b1);
        checkOutput("sw_done_we", ram_we, 1'b0);

        $display("[TB] fill to full then release");
        gntMode = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(32'h0000_1100 + 32'(k), 32'(8'hA0 + k), 4'd0, 1'b0);
        end
        @(posedge clk); #1;
        st_addr = 32'h0000_1104;
        st_data = 32'h0000_00A4;
        st_len  = 4'd0;
        st_ena  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("full_no_ack", st_done, 1'b0);
        end
        checkOutput("full_flag", sb_full, 1'b1);
        gntMode = 1;
        waited = 0;
        got = 0;
        while (!got && waited < 20) begin
            @(negedge clk);
            waited++;
            if (st_done) got = 1;
        end
        checkOutput("fifth_ack_cycle", waited, 32'd2);
        if (got) recordAccept(32'h0000_1104, 32'h0000_00A4, 4'd0);
        st_ena = 1'b0;
        waitDrain();

        $display("[TB] I/O region stall");
        ioMode = 1;
        applyStimulus(32'h0003_0000, 32'h0000_005A, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("io_stall_we", ram_we, 1'b0);
        end
        ioMode = 0;
        got = 0;
        for (int w = 0; w < 5 && !got; w++) begin
            @(negedge clk);
            if (ram_we) got = 1;
        end
        checkOutput("io_released_write", got, 1'b1);
        waitDrain();

        $display("[TB] load overlap");
        gntMode = 0;
        applyStimulus(32'h0000_2002, 32'h0000_BEEF, 4'd1, 1'b1);
        ldFix = 1;
        ldAddrFix = 32'h0000_2000;
        ldLenFix = 4'd3;
        repeat (2) @(negedge clk);
        checkOutput("conflict_hit", ld_conflict, 1'b1);
        ldAddrFix = 32'h0000_2004;
        repeat (2) @(negedge clk);
        checkOutput("conflict_miss", ld_conflict, 1'b0);
        ldFix = 0;
        gntMode = 1;
        waitDrain();

        $display("[TB] reset mid-drain");
        applyStimulus(32'h0000_4000, 32'hDEAD_BEEF, 4'd3, 1'b0);
        @(negedge clk);
        checkOutput("rst_first_byte", ram_we, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        pendQ.delete();
        expQ.delete();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("post_rst_we", ram_we, 1'b0);
            checkOutput("post_rst_empty", sb_empty, 1'b1);
        end

        $display("[TB] randomized traffic");
        gntMode = 2;
        ioMode = 2;
        for (int n = 0; n < 60; n++) begin
            applyStimulus(bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 7)),
                          $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        ioMode = 0;
        waitDrain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_drain_buffer.md
# store_drain_buffer

Committed-store buffer between the reorder buffer's store-commit port and the byte-wide unified RAM port of the memory controller. It acknowledges each committed store one cycle after accepting it, holds up to DEPTH stores in program order, and drains them one byte per granted cycle. It stalls I/O-region writes while the UART buffer is full and reports overlap between a pending store and a load address so the load path can hold off.

## Interface
- DEPTH, 4: entries; power of two, ≥2
- IDX_BIT, 2: log2(DEPTH)
- IO_SEL, 2'b11: value of addr[17:16] marking the I/O region
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- rdy  in  1  global ready; low freezes all state and outputs, including the done pulse
- st_ena  in  1  commit-side store request; level, held until st_done is seen
- st_addr  in  32  byte address
- st_data  in  32  store data, little-endian, low bytes valid
- st_len  in  4  bytes minus one: 0 = SB, 1 = SH, 3 = SW; other values are treated as 3
- st_done  out  1  one-cycle acknowledge, registered
- mem_gnt  in  1  memory controller grants the RAM port to this block this cycle
- io_buffer_full  in  1  UART buffer full
- ram_we  out  1  byte write strobe
- ram_a  out  32  byte address
- ram_dout  out  8  write byte
- ld_chk_addr  in  32  load address to check
- ld_chk_len  in  4  load length minus one
- ld_conflict  out  1  combinational; a pending byte overlaps the load range
- sb_empty  out  1  no pending entries; memory controller may serve loads freely
- sb_full  out  1  count == DEPTH

## Operation
- Storage: circular FIFO of {addr, data, len} with head, tail, and count (IDX_BIT+1 bits). Pointers wrap from DEPTH-1 to 0.
- Accept:
  - Condition: st_ena && !acked && count < DEPTH.
  - Action: push at tail, set acked, and drive st_done = 1 on the next cycle.
  - acked clears when st_ena is sampled low.
  - The handshake guarantees at least one low cycle between requests. A request held high after st_done never produces a second push.
- Full: the request waits, st_done stays low, and it is accepted on the first cycle count < DEPTH. This includes the cycle in which a pop completes.
- Drain FSM:
  - IDLE: if count > 0, load the head entry, set byte_idx = 0, and go to WRITE.
  - WRITE: a byte is emitted in a cycle when mem_gnt is high and the entry is not blocked.
    - Blocked means (addr[17:16] == IO_SEL && io_buffer_full).
    - Emitted byte: ram_we = 1, ram_a = addr + byte_idx, ram_dout = data[8*byte_idx +: 8].
    - byte_idx increments on each emitted byte.
    - When byte_idx == len, pop the head and return to IDLE. If count > 1, load the next entry directly instead, with no idle bubble.
    - With mem_gnt low or blocked: ram_we = 0, state held.
- Address arithmetic is 32-bit modulo; byte offsets never carry out of the store.
- ld_conflict: OR over every valid entry, including the one being drained, of a range overlap on the full 32-bit address.
  - Store range is [addr, addr+len]; load range is [ld_chk_addr, ld_chk_addr+ld_chk_len].
  - Bytes of the draining entry that are already written still count as pending.
- Pipeline rollback does not touch this block; committed stores are never flushed.
- Push and pop in the same cycle: count unchanged, both pointers advance.

## Timing
- Reset (rst_n low at an edge) gives:
  - outputs: st_done = 0, ram_we = 0, ram_a = 0, ram_dout = 0, sb_empty = 1, sb_full = 0;
  - internal state: count = 0, head = tail = 0, acked = 0, FSM = IDLE.
- Reset mid-drain abandons the remaining bytes; ram_we is low from the next cycle.
- Accept latency: request sampled at edge N; st_done is high during cycle N+1 only.
- First byte: entry pushed at edge N reaches IDLE at N+1 (empty buffer), is loaded, and its first write can appear in cycle N+2.
- Throughput: SW = 4 granted cycles, SH = 2, SB = 1.
- sb_empty and sb_full are registered from count.

## Test plan
- SW, addr 0x1000, data 0x11223344, mem_gnt = 1 → st_done one cycle; writes 0x44@0x1000, 0x33@0x1001, 0x22@0x1002, 0x11@0x1003 on consecutive cycles; then sb_empty = 1.
- Five back-to-back SB with mem_gnt = 0, DEPTH = 4 → four acks, sb_full = 1, fifth request has no st_done. Raising mem_gnt → fifth ack on the cycle the first pop completes; five bytes written in order.
- SB to 0x30000 with io_buffer_full = 1 for 3 cycles → no ram_we during those cycles; single write of the byte once io_buffer_full = 0.
- Pending SH at 0x2002 → ld_conflict = 1 for a load at 0x2000 with len 3, and 0 for a load at 0x2004 with len 3.
- st_ena held high for 3 cycles after st_done → exactly one entry pushed.
- rst_n low during the second byte of a SW → ram_we = 0 next cycle, sb_empty = 1, no further writes.
